// File: rtl/i2c_xlate_sched.sv
// I2C address translator / scheduler.
// An upstream slave front end stretches SCL while this block decides what to
// do with each captured address or write byte. Writes to one of two virtual
// addresses are forwarded to a downstream master on bus A or bus B under the
// matching physical address; anything else is NACKed upstream. Every
// downstream step is guarded by a timeout so a dead bus cannot hold the
// upstream clock stretched forever.
module i2c_xlate_sched #(
    parameter int          NUM_BYTES_WR = 3,
    parameter logic [6:0]  VADDR_A      = 7'h58,
    parameter logic [6:0]  VADDR_B      = 7'h59,
    parameter logic [6:0]  PADDR_A      = 7'h48,
    parameter logic [6:0]  PADDR_B      = 7'h49,
    parameter logic [15:0] TIMEOUT_CYC  = 16'd50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       us_req,
    input  logic [6:0] us_addr,
    input  logic       us_rw,
    input  logic       us_byte_valid,
    input  logic [7:0] us_byte,
    input  logic       us_stop,
    output logic       us_release,
    output logic       us_ack,
    output logic       dm_start,
    output logic [1:0] dm_sel,
    output logic [6:0] dm_addr,
    output logic       dm_rw,
    output logic       dm_wvalid,
    output logic [7:0] dm_wdata,
    input  logic       dm_done,
    input  logic       dm_ack,
    input  logic       dm_busy,
    output logic       dm_stop,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WAIT_ADDR,
        XFER,
        WAIT_BYTE,
        STOP
    } state_t;

    localparam logic [1:0]  MAX_BYTES  = 2'(NUM_BYTES_WR);
    localparam logic [15:0] TIMER_LAST = TIMEOUT_CYC - 16'd1;

    state_t      state_reg, state_next;
    logic [6:0]  addr_reg, addr_next;
    logic        rw_reg, rw_next;
    logic [1:0]  count_reg, count_next;
    logic [15:0] timer_reg, timer_next;
    logic        stop_pend_reg, stop_pend_next;

    logic        us_release_reg, us_release_next;
    logic        us_ack_reg, us_ack_next;
    logic        dm_start_reg, dm_start_next;
    logic [1:0]  dm_sel_reg, dm_sel_next;
    logic [6:0]  dm_addr_reg, dm_addr_next;
    logic        dm_wvalid_reg, dm_wvalid_next;
    logic [7:0]  dm_wdata_reg, dm_wdata_next;
    logic        dm_stop_reg, dm_stop_next;
    logic        err_timeout_reg, err_timeout_next;

    // One compare per virtual address; bit 0 = bus A, bit 1 = bus B.
    logic [1:0] addr_hit;
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_map
            localparam logic [6:0] VADDR = (gi == 0) ? VADDR_A : VADDR_B;
            assign addr_hit[gi] = (addr_reg == VADDR);
        end
    endgenerate

    // State and registered outputs; reset drops everything without a STOP.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            rw_reg          <= 1'b0;
            count_reg       <= '0;
            timer_reg       <= '0;
            stop_pend_reg   <= 1'b0;
            us_release_reg  <= 1'b0;
            us_ack_reg      <= 1'b0;
            dm_start_reg    <= 1'b0;
            dm_sel_reg      <= 2'b00;
            dm_addr_reg     <= '0;
            dm_wvalid_reg   <= 1'b0;
            dm_wdata_reg    <= '0;
            dm_stop_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            rw_reg          <= rw_next;
            count_reg       <= count_next;
            timer_reg       <= timer_next;
            stop_pend_reg   <= stop_pend_next;
            us_release_reg  <= us_release_next;
            us_ack_reg      <= us_ack_next;
            dm_start_reg    <= dm_start_next;
            dm_sel_reg      <= dm_sel_next;
            dm_addr_reg     <= dm_addr_next;
            dm_wvalid_reg   <= dm_wvalid_next;
            dm_wdata_reg    <= dm_wdata_next;
            dm_stop_reg     <= dm_stop_next;
            err_timeout_reg <= err_timeout_next;
        end
    end

    // Next-state and output decisions; pulses default low, the rest hold.
    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        rw_next          = rw_reg;
        count_next       = count_reg;
        timer_next       = timer_reg;
        stop_pend_next   = stop_pend_reg;
        us_release_next  = 1'b0;
        us_ack_next      = us_ack_reg;
        dm_start_next    = 1'b0;
        dm_sel_next      = dm_sel_reg;
        dm_addr_next     = dm_addr_reg;
        dm_wvalid_next   = 1'b0;
        dm_wdata_next    = dm_wdata_reg;
        dm_stop_next     = 1'b0;
        err_timeout_next = err_timeout_reg;

        case (state_reg)
            IDLE: begin
                if (us_req) begin
                    addr_next        = us_addr;
                    rw_next          = us_rw;
                    err_timeout_next = 1'b0;
                    stop_pend_next   = 1'b0;
                    state_next       = LOOKUP;
                end
            end

            LOOKUP: begin
                if ((addr_hit != 2'b00) && !rw_reg) begin
                    dm_sel_next   = addr_hit[0] ? 2'b01 : 2'b10;
                    dm_addr_next  = addr_hit[0] ? PADDR_A : PADDR_B;
                    dm_start_next = 1'b1;
                    count_next    = '0;
                    timer_next    = '0;
                    state_next    = WAIT_ADDR;
                end else begin
                    // Reads and unknown addresses are refused upstream.
                    us_release_next = 1'b1;
                    us_ack_next     = 1'b0;
                    state_next      = IDLE;
                end
            end

            WAIT_ADDR, WAIT_BYTE: begin
                // A STOP seen while waiting is deferred until the byte resolves.
                if (us_stop) begin
                    stop_pend_next = 1'b1;
                end
                if (dm_done) begin
                    // dm_done wins even on the cycle the timer would expire.
                    us_release_next = 1'b1;
                    us_ack_next     = dm_ack;
                    if ((state_reg == WAIT_BYTE) && (count_reg < MAX_BYTES)) begin
                        count_next = count_reg + 2'd1;
                    end
                    if (dm_ack && !stop_pend_reg && !us_stop) begin
                        state_next = XFER;
                    end else begin
                        state_next = STOP;
                    end
                end else if (timer_reg >= TIMER_LAST) begin
                    us_release_next  = 1'b1;
                    us_ack_next      = 1'b0;
                    err_timeout_next = 1'b1;
                    state_next       = STOP;
                end else begin
                    timer_next = timer_reg + 16'd1;
                end
            end

            XFER: begin
                if (us_stop) begin
                    state_next = STOP;
                end else if (us_byte_valid) begin
                    if (count_reg < MAX_BYTES) begin
                        dm_wvalid_next = 1'b1;
                        dm_wdata_next  = us_byte;
                        timer_next     = '0;
                        state_next     = WAIT_BYTE;
                    end else begin
                        // Byte budget used up: NACK without forwarding.
                        us_release_next = 1'b1;
                        us_ack_next     = 1'b0;
                    end
                end
            end

            STOP: begin
                if (!dm_busy) begin
                    dm_sel_next = 2'b00;
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Downstream STOP is issued exactly once, as STOP is entered.
        if ((state_next == STOP) && (state_reg != STOP)) begin
            dm_stop_next = 1'b1;
        end
    end

    assign us_release  = us_release_reg;
    assign us_ack      = us_ack_reg;
    assign dm_start    = dm_start_reg;
    assign dm_sel      = dm_sel_reg;
    assign dm_addr     = dm_addr_reg;
    assign dm_rw       = 1'b0;
    assign dm_wvalid   = dm_wvalid_reg;
    assign dm_wdata    = dm_wdata_reg;
    assign dm_stop     = dm_stop_reg;
    assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_i2c_xlate_sched.sv
// Directed bench for i2c_xlate_sched: forwarding, byte limit, refusals,
// deferred STOP, mid-transaction reset and the downstream timeout.
module tb_i2c_xlate_sched;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       us_req = 1'b0;
    logic [6:0] us_addr = '0;
    logic       us_rw = 1'b0;
    logic       us_byte_valid = 1'b0;
    logic [7:0] us_byte = '0;
    logic       us_stop = 1'b0;
    logic       us_release;
    logic       us_ack;
    logic       dm_start;
    logic [1:0] dm_sel;
    logic [6:0] dm_addr;
    logic       dm_rw;
    logic       dm_wvalid;
    logic [7:0] dm_wdata;
    logic       dm_done = 1'b0;
    logic       dm_ack = 1'b0;
    logic       dm_busy = 1'b0;
    logic       dm_stop;
    logic       err_timeout;

    int total = 0;
    int bad = 0;

    // Pulse counters and the values captured with each pulse.
    int         n_release = 0;
    int         n_start = 0;
    int         n_wvalid = 0;
    int         n_stop = 0;
    logic       last_ack = 1'b0;
    logic [7:0] last_wdata = '0;
    logic [1:0] last_sel = '0;
    logic [6:0] last_addr = '0;

    i2c_xlate_sched dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .us_req        (us_req),
        .us_addr       (us_addr),
        .us_rw         (us_rw),
        .us_byte_valid (us_byte_valid),
        .us_byte       (us_byte),
        .us_stop       (us_stop),
        .us_release    (us_release),
        .us_ack        (us_ack),
        .dm_start      (dm_start),
        .dm_sel        (dm_sel),
        .dm_addr       (dm_addr),
        .dm_rw         (dm_rw),
        .dm_wvalid     (dm_wvalid),
        .dm_wdata      (dm_wdata),
        .dm_done       (dm_done),
        .dm_ack        (dm_ack),
        .dm_busy       (dm_busy),
        .dm_stop       (dm_stop),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    // Pulse monitor on the falling edge, away from the stimulus time points.
    always @(negedge clk) begin
        if (reset_n) begin
            if (us_release) begin
                n_release = n_release + 1;
                last_ack  = us_ack;
            end
            if (dm_start) begin
                n_start   = n_start + 1;
                last_sel  = dm_sel;
                last_addr = dm_addr;
            end
            if (dm_wvalid) begin
                n_wvalid   = n_wvalid + 1;
                last_wdata = dm_wdata;
            end
            if (dm_stop) begin
                n_stop = n_stop + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int count_of(input int which);
        case (which)
            0:       return n_release;
            1:       return n_start;
            2:       return n_wvalid;
            default: return n_stop;
        endcase
    endfunction

    // Bounded wait for the next pulse of the selected kind.
    task automatic wait_pulse(input string tag, input int which, input int max);
        int  base;
        logic seen;
        base = count_of(which);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            step(1);
            if (count_of(which) != base) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic pulse_req(input logic [6:0] addr, input logic rw);
        us_req  = 1'b1;
        us_addr = addr;
        us_rw   = rw;
        step(1);
        us_req  = 1'b0;
        us_addr = '0;
        us_rw   = 1'b0;
    endtask

    task automatic pulse_byte(input logic [7:0] b);
        us_byte_valid = 1'b1;
        us_byte       = b;
        step(1);
        us_byte_valid = 1'b0;
        us_byte       = '0;
    endtask

    task automatic pulse_done(input logic ack);
        dm_done = 1'b1;
        dm_ack  = ack;
        step(1);
        dm_done = 1'b0;
        dm_ack  = 1'b0;
    endtask

    task automatic pulse_stop();
        us_stop = 1'b1;
        step(1);
        us_stop = 1'b0;
    endtask

    logic [7:0] wr_bytes [3];
    int         base_rel;
    int         base_start;
    int         base_wv;
    int         base_stop;
    logic       early_rel;
    logic       late_seen;

    initial begin
        wr_bytes[0] = 8'h10;
        wr_bytes[1] = 8'hAA;
        wr_bytes[2] = 8'h55;

        // Reset state: every output low.
        reset_n = 1'b0;
        step(3);
        check("reset_outputs",
              {8'd0, us_release, us_ack, dm_start, dm_sel, dm_addr, dm_rw,
               dm_wvalid, dm_wdata, dm_stop, err_timeout}, 32'd0);
        reset_n = 1'b1;
        step(2);

        // Write to virtual A, address phase acked.
        pulse_req(7'h58, 1'b0);
        wait_pulse("a_start_seen", 1, 8);
        check("a_start_count", n_start, 1);
        check("a_sel", {30'd0, last_sel}, 32'd1);
        check("a_paddr", {25'd0, last_addr}, 32'h48);
        check("a_rw", {31'd0, dm_rw}, 32'd0);
        dm_busy = 1'b1;
        pulse_done(1'b1);
        wait_pulse("a_addr_rel_seen", 0, 8);
        check("a_addr_ack", {31'd0, last_ack}, 32'd1);
        $display("txn: addr 58 write -> bus A addr 48, ack=%0b", last_ack);

        // A new us_req mid-transaction must be ignored.
        base_rel = n_release;
        pulse_req(7'h30, 1'b0);
        step(4);
        check("ignore_req_busy", n_release, base_rel);

        // Three forwarded bytes, then one over the limit.
        for (int b = 0; b < 3; b++) begin
            pulse_byte(wr_bytes[b]);
            wait_pulse("byte_wvalid_seen", 2, 8);
            check("byte_wdata", {24'd0, last_wdata}, {24'd0, wr_bytes[b]});
            pulse_done(1'b1);
            wait_pulse("byte_rel_seen", 0, 8);
            check("byte_ack", {31'd0, last_ack}, 32'd1);
            $display("txn: byte %0h forwarded, ack=%0b", wr_bytes[b], last_ack);
        end
        base_wv = n_wvalid;
        pulse_byte(8'h77);
        wait_pulse("over_rel_seen", 0, 8);
        check("over_ack", {31'd0, last_ack}, 32'd0);
        step(3);
        check("over_no_wvalid", n_wvalid, base_wv);
        check("wvalid_total", n_wvalid, 3);
        $display("txn: byte 77 over limit, ack=%0b", last_ack);

        // Upstream STOP in XFER; bus select held while downstream busy.
        pulse_stop();
        wait_pulse("a_stop_seen", 3, 8);
        step(2);
        check("sel_held_busy", {30'd0, dm_sel}, 32'd1);
        dm_busy = 1'b0;
        step(3);
        check("sel_clear_idle", {30'd0, dm_sel}, 32'd0);
        $display("txn: stop on bus A, stops=%0d", n_stop);

        // Unknown address and a read: refused, nothing started downstream.
        base_start = n_start;
        pulse_req(7'h30, 1'b0);
        wait_pulse("unk_rel_seen", 0, 8);
        check("unk_ack", {31'd0, last_ack}, 32'd0);
        $display("txn: addr 30 refused, ack=%0b", last_ack);
        pulse_req(7'h59, 1'b1);
        wait_pulse("rd_rel_seen", 0, 8);
        check("rd_ack", {31'd0, last_ack}, 32'd0);
        step(3);
        check("refuse_no_start", n_start, base_start);
        $display("txn: addr 59 read refused, ack=%0b", last_ack);

        // STOP during WAIT_BYTE, then the byte is NACKed downstream.
        pulse_req(7'h59, 1'b0);
        wait_pulse("b_start_seen", 1, 8);
        check("b_sel", {30'd0, last_sel}, 32'd2);
        check("b_paddr", {25'd0, last_addr}, 32'h49);
        dm_busy = 1'b1;
        pulse_done(1'b1);
        wait_pulse("b_addr_rel_seen", 0, 8);
        pulse_byte(8'h3C);
        wait_pulse("b_wvalid_seen", 2, 8);
        base_rel  = n_release;
        base_stop = n_stop;
        pulse_stop();
        step(3);
        check("defer_no_rel", n_release, base_rel);
        check("defer_no_stop", n_stop, base_stop);
        pulse_done(1'b0);
        wait_pulse("b_nack_rel_seen", 0, 8);
        check("b_nack_ack", {31'd0, last_ack}, 32'd0);
        step(5);
        check("b_single_stop", n_stop, base_stop + 1);
        dm_busy = 1'b0;
        step(3);
        check("b_sel_clear", {30'd0, dm_sel}, 32'd0);
        $display("txn: addr 59 byte 3c nack after stop, stops=%0d", n_stop - base_stop);

        // Reset while waiting on a byte, then a fresh transaction.
        pulse_req(7'h58, 1'b0);
        wait_pulse("r_start_seen", 1, 8);
        dm_busy = 1'b1;
        pulse_done(1'b1);
        wait_pulse("r_addr_rel_seen", 0, 8);
        pulse_byte(8'h99);
        wait_pulse("r_wvalid_seen", 2, 8);
        base_stop = n_stop;
        reset_n = 1'b0;
        step(1);
        check("midreset_outputs",
              {8'd0, us_release, us_ack, dm_start, dm_sel, dm_addr, dm_rw,
               dm_wvalid, dm_wdata, dm_stop, err_timeout}, 32'd0);
        reset_n = 1'b1;
        dm_busy = 1'b0;
        step(3);
        check("midreset_no_stop", n_stop, base_stop);
        pulse_req(7'h58, 1'b0);
        wait_pulse("post_start_seen", 1, 8);
        pulse_done(1'b1);
        wait_pulse("post_rel_seen", 0, 8);
        check("post_ack", {31'd0, last_ack}, 32'd1);
        pulse_stop();
        wait_pulse("post_stop_seen", 3, 8);
        step(3);
        $display("txn: reset in WAIT_BYTE, then addr 58 serviced, ack=%0b", last_ack);

        // Timeout: address phase never completes.
        dm_busy = 1'b1;
        pulse_req(7'h59, 1'b0);
        late_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (dm_start) begin
                late_seen = 1'b1;
                break;
            end
            step(1);
        end
        check("to_start_seen", {31'd0, late_seen}, 32'd1);
        base_stop = n_stop;
        early_rel = 1'b0;
        for (int i = 0; i < 49998; i++) begin
            step(1);
            if (us_release) early_rel = 1'b1;
        end
        check("to_no_early_rel", {31'd0, early_rel}, 32'd0);
        late_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (us_release) begin
                late_seen = 1'b1;
                break;
            end
        end
        check("to_rel_seen", {31'd0, late_seen}, 32'd1);
        check("to_ack", {31'd0, us_ack}, 32'd0);
        check("to_err", {31'd0, err_timeout}, 32'd1);
        step(3);
        check("to_stop_count", n_stop, base_stop + 1);
        check("to_sel_held", {30'd0, dm_sel}, 32'd2);
        dm_busy = 1'b0;
        step(3);
        check("to_sel_clear", {30'd0, dm_sel}, 32'd0);
        check("to_err_sticky", {31'd0, err_timeout}, 32'd1);
        $display("txn: addr 59 timeout, err_timeout=%0b", err_timeout);

        // Next accepted request clears the sticky flag.
        pulse_req(7'h30, 1'b0);
        wait_pulse("clr_rel_seen", 0, 8);
        check("err_cleared", {31'd0, err_timeout}, 32'd0);
        $display("txn: addr 30 refused, err_timeout=%0b", err_timeout);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_xlate_sched.md
I2C_XLATE_SCHED -- requirements
Module: i2c_xlate_sched

Interface
REQ-001 SHALL have parameter NUM_BYTES_WR, default 3: maximum data bytes forwarded per write transaction (1..3).
REQ-002 SHALL have parameter VADDR_A, default 7'h58: upstream (virtual) address mapped to bus A.
REQ-003 SHALL have parameter VADDR_B, default 7'h59: upstream (virtual) address mapped to bus B.
REQ-004 SHALL have parameter PADDR_A, default 7'h48, and PADDR_B, default 7'h49: physical downstream addresses for bus A and bus B.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 16'd50000: clk cycles allowed for each downstream dm_done.
REQ-006 SHALL use one clock and a synchronous, active-low reset; clock and reset ports are named as below.
REQ-007 clk  in  1  100 MHz system clock, rising edge.
REQ-008 reset_n  in  1  synchronous active-low reset.
REQ-009 us_req  in  1  pulse: upstream slave captured an address byte and is stretching SCL.
REQ-010 us_addr  in  7  address captured with us_req.
REQ-011 us_rw  in  1  R/W bit captured with us_req; 1 = read.
REQ-012 us_byte_valid  in  1  pulse: upstream captured one write data byte and is stretching SCL.
REQ-013 us_byte  in  8  data byte qualified by us_byte_valid.
REQ-014 us_stop  in  1  pulse: STOP condition detected on the upstream bus.
REQ-015 us_release  out  1  pulse: upstream may drive ACK/NACK and release the stretch.
REQ-016 us_ack  out  1  qualified by us_release; 1 = ACK, 0 = NACK.
REQ-017 dm_start  out  1  pulse: start a downstream transaction to dm_sel/dm_addr/dm_rw.
REQ-018 dm_sel  out  2  target bus: 2'b01 = A, 2'b10 = B, 2'b00 = none; held for the whole transaction.
REQ-019 dm_addr  out  7  physical address; dm_rw  out  1  always 0 (write).
REQ-020 dm_wvalid  out  1  pulse: write dm_wdata downstream; dm_wdata  out  8  byte to write.
REQ-021 dm_done  in  1  pulse: downstream finished the address or data byte; dm_ack  in  1  ACK sampled with dm_done.
REQ-022 dm_busy  in  1  downstream master is active on the bus.
REQ-023 dm_stop  out  1  pulse: issue STOP downstream.
REQ-024 err_timeout  out  1  sticky flag; cleared on the next accepted us_req.

Function
REQ-025 SHALL implement the states IDLE, LOOKUP, WAIT_ADDR, XFER, WAIT_BYTE and STOP.
REQ-026 IDLE: on us_req, SHALL latch us_addr and us_rw and enter LOOKUP on the next cycle; us_req SHALL be ignored in every other state.
REQ-027 LOOKUP, address match with us_rw = 0: SHALL set dm_sel and dm_addr, pulse dm_start for 1 cycle, clear the byte count and timer, and enter WAIT_ADDR.
REQ-028 LOOKUP, no match or us_rw = 1: SHALL pulse us_release with us_ack = 0 and return to IDLE; dm_start SHALL NOT assert.
REQ-029 WAIT_ADDR, on dm_done: SHALL pulse us_release with us_ack = dm_ack in the following cycle; enter XFER on ACK, or STOP on NACK.
REQ-030 XFER, on us_byte_valid with byte count < NUM_BYTES_WR: SHALL pulse dm_wvalid with dm_wdata = us_byte in the following cycle, clear the timer, and enter WAIT_BYTE.
REQ-031 XFER, on us_byte_valid with byte count = NUM_BYTES_WR: SHALL pulse us_release with us_ack = 0 without forwarding the byte, and remain in XFER.
REQ-032 WAIT_BYTE, on dm_done: SHALL pulse us_release with us_ack = dm_ack and increment the byte count (saturating); enter XFER on ACK, or STOP on NACK.
REQ-033 us_stop in XFER SHALL enter STOP; us_stop in WAIT_ADDR or WAIT_BYTE SHALL be latched and STOP entered after the dm_done handling.
REQ-034 Timer SHALL count in WAIT_ADDR and WAIT_BYTE; at TIMEOUT_CYC without dm_done it SHALL pulse us_release with us_ack = 0, set err_timeout, and enter STOP.
REQ-035 dm_done arriving in the same cycle the timer expires SHALL take priority over the timeout.
REQ-036 STOP: SHALL pulse dm_stop in the entry cycle, then wait until dm_busy = 0, then set dm_sel = 0 and enter IDLE.
REQ-037 Exactly one us_release pulse SHALL be produced per us_req and per us_byte_valid that is accepted.

Reset
REQ-038 While reset_n = 0 at a clk edge: state = IDLE; all pulse outputs, dm_sel, dm_addr, dm_wdata, us_ack and err_timeout = 0; counters cleared.
REQ-039 Reset asserted mid-transaction SHALL abort without a dm_stop pulse.

Verification
REQ-040 us_req addr 7'h58, rw 0; dm_done with ack = 1 -> dm_start, dm_sel = 01, dm_addr = 7'h48; then us_release with us_ack = 1.
REQ-041 Three bytes 0x10/0xAA/0x55 acked, then a 4th byte -> three dm_wvalid pulses with matching data; the 4th gets us_ack = 0 and no dm_wvalid.
REQ-042 us_req addr 7'h30, and separately addr 7'h59 with rw = 1 -> us_release with us_ack = 0; no dm_start.
REQ-043 addr 7'h59, dm_done withheld -> after 50000 cycles: us_release with us_ack = 0, err_timeout = 1, dm_stop pulse; dm_sel = 0 after dm_busy falls.
REQ-044 us_stop during WAIT_BYTE, then dm_done with ack = 0 -> us_release with us_ack = 0, then a single dm_stop pulse, then IDLE.
REQ-045 reset_n low in WAIT_BYTE -> all outputs 0 at the next edge; a subsequent us_req is serviced normally.
